lpc_product_decoder: RTL and testbench

Parametrised AXI4-Stream decoder for the row/column product-parity (LPC) code: accepts one ROWS×COLS data block plus ROWS row-parity and COLS column-parity bits per beat and emits the corrected data block with a per-beat error status. It is the fully pipelined successor of the fixed 8×8 decoder. It sustains one beat per clock under back-pressure, forwards TUSER/TLAST, classifies parity-only errors and uncorrectable patterns, and keeps saturating error counters. It sits between the channel/deserialiser and the sample consumer.

---
 rtl/lpc_product_decoder_pkg.sv | 24 ++
 rtl/lpc_syndrome.sv | 32 +++
 rtl/lpc_product_decoder.sv | 191 +++++++++++++++++++
 tb/tb_lpc_product_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_product_decoder_pkg.sv
// Shared definitions for the row/column product-parity (LPC) code:
// status encodings and coded-word layout helpers.
package lpc_pkg;

  typedef enum logic [1:0] {
    LPC_CLEAN     = 2'b00,
    LPC_CORR_DATA = 2'b01,
    LPC_CORR_PAR  = 2'b10,
    LPC_UNCORR    = 2'b11
  } lpc_status_e;

  function automatic int lpc_coded_w(input int rows, input int cols);
    return rows * cols + rows + cols;
  endfunction

  function automatic int lpc_row_par_idx(input int rows, input int cols, input int r);
    return rows * cols + r;
  endfunction

  function automatic int lpc_col_par_idx(input int rows, input int cols, input int c);
    return rows * cols + rows + c;
  endfunction

endpackage

// File: rtl/lpc_syndrome.sv
// Row and column syndromes of one LPC coded word (even parity, zero = consistent).
// Purely combinational; also usable for parity generation with parity bits tied to 0.
module lpc_syndrome
  import lpc_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic [lpc_coded_w(ROWS, COLS)-1:0] i_code,
  output logic [ROWS-1:0]                    o_rs,
  output logic [COLS-1:0]                    o_cs
);

  // XOR every data bit into its row and column, then fold in the parity bits
  always_comb begin
    o_rs = '0;
    o_cs = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        o_rs[r] = o_rs[r] ^ i_code[r * COLS + c];
        o_cs[c] = o_cs[c] ^ i_code[r * COLS + c];
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      o_rs[r] = o_rs[r] ^ i_code[lpc_row_par_idx(ROWS, COLS, r)];
    end
    for (int c = 0; c < COLS; c++) begin
      o_cs[c] = o_cs[c] ^ i_code[lpc_col_par_idx(ROWS, COLS, c)];
    end
  end

endmodule

// File: rtl/lpc_product_decoder.sv
// Two-stage AXI4-Stream LPC decoder: S1 registers beat + syndromes, S2 registers
// the corrected block and status. Saturating correction/uncorrectable counters.
module lpc_product_decoder
  import lpc_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int CW          = 16,
  parameter int DROP_UNCORR = 0
) (
  input  logic                               ACLK,
  input  logic                               ARESET_N,
  input  logic [lpc_coded_w(ROWS, COLS)-1:0] TDATA,
  input  logic                               TVALID,
  output logic                               TREADY,
  input  logic                               TUSER,
  input  logic                               TLAST,
  output logic [ROWS*COLS-1:0]               OUT_DECODED,
  output logic                               OUT_VALID,
  input  logic                               OUT_READY,
  output logic                               OUT_LAST,
  output logic                               OUT_USER,
  output logic [1:0]                         OUT_STATUS,
  output logic [CW-1:0]                      CNT_CORR,
  output logic [CW-1:0]                      CNT_UNCORR,
  input  logic                               CNT_CLR
);

  localparam int N = ROWS * COLS;

  logic [ROWS-1:0] w_rs;
  logic [COLS-1:0] w_cs;

  logic            r_s1_valid;
  logic [N-1:0]    r_s1_data;
  logic [ROWS-1:0] r_s1_rs;
  logic [COLS-1:0] r_s1_cs;
  logic            r_s1_user;
  logic            r_s1_last;

  logic            r_s2_valid;
  logic [N-1:0]    r_s2_data;
  lpc_status_e     r_s2_status;
  logic            r_s2_user;
  logic            r_s2_last;

  logic [CW-1:0]   r_cnt_corr;
  logic [CW-1:0]   r_cnt_uncorr;

  logic            w_s2_load;
  logic            w_s1_load;
  logic            w_hs_out;
  logic            w_drop;
  logic            w_dropped;
  logic            w_rs_zero;
  logic            w_rs_one;
  logic            w_cs_zero;
  logic            w_cs_one;
  lpc_status_e     w_status;
  logic [N-1:0]    w_flip;
  logic [N-1:0]    w_dec;
  logic [1:0]      w_inc_corr;
  logic [1:0]      w_inc_uncorr;
  logic [CW-1:0]   w_corr_next;
  logic [CW-1:0]   w_uncorr_next;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt, input logic [1:0] inc);
    logic [CW:0] sum;
    sum = {1'b0, cnt} + (CW+1)'(inc);
    if (sum[CW]) begin
      return {CW{1'b1}};
    end else begin
      return sum[CW-1:0];
    end
  endfunction

  lpc_syndrome #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_syndrome (
    .i_code(TDATA),
    .o_rs  (w_rs),
    .o_cs  (w_cs)
  );

  assign w_s2_load = ~r_s2_valid | OUT_READY;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign TREADY    = w_s1_load;
  assign w_hs_out  = r_s2_valid & OUT_READY;

  // Popcount classes 0 / exactly-1 / more via the clear-lowest-set-bit trick
  always_comb begin
    w_rs_zero = ~|r_s1_rs;
    w_cs_zero = ~|r_s1_cs;
    w_rs_one  = ~w_rs_zero && ((r_s1_rs & (r_s1_rs - ROWS'(1))) == '0);
    w_cs_one  = ~w_cs_zero && ((r_s1_cs & (r_s1_cs - COLS'(1))) == '0);
    if (w_rs_zero && w_cs_zero) begin
      w_status = LPC_CLEAN;
    end else if (w_rs_one && w_cs_one) begin
      w_status = LPC_CORR_DATA;
    end else if ((w_rs_one && w_cs_zero) || (w_rs_zero && w_cs_one)) begin
      w_status = LPC_CORR_PAR;
    end else begin
      w_status = LPC_UNCORR;
    end
  end

  // With one row and one column flagged, the outer product marks exactly the bad bit
  always_comb begin
    w_flip = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_flip[r * COLS + c] = r_s1_rs[r] & r_s1_cs[c];
      end
    end
    if (w_status == LPC_CORR_DATA) begin
      w_dec = r_s1_data ^ w_flip;
    end else begin
      w_dec = r_s1_data;
    end
  end

  assign w_drop    = (DROP_UNCORR != 0) && (w_status == LPC_UNCORR) && !r_s1_last;
  assign w_dropped = r_s1_valid & w_s2_load & w_drop;

  always_comb begin
    w_inc_corr    = {1'b0, w_hs_out && ((r_s2_status == LPC_CORR_DATA) || (r_s2_status == LPC_CORR_PAR))};
    w_inc_uncorr  = {1'b0, w_hs_out && (r_s2_status == LPC_UNCORR)} + {1'b0, w_dropped};
    w_corr_next   = sat_add(r_cnt_corr, w_inc_corr);
    w_uncorr_next = sat_add(r_cnt_uncorr, w_inc_uncorr);
  end

  // Stage 1: captured input beat and its syndromes
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_rs    <= '0;
      r_s1_cs    <= '0;
      r_s1_user  <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= TVALID;
      r_s1_data  <= TDATA[N-1:0];
      r_s1_rs    <= w_rs;
      r_s1_cs    <= w_cs;
      r_s1_user  <= TUSER;
      r_s1_last  <= TLAST;
    end
  end

  // Stage 2: output register; a dropped beat leaves it empty
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_s2_status <= LPC_CLEAN;
      r_s2_user   <= 1'b0;
      r_s2_last   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid  <= r_s1_valid & ~w_drop;
      r_s2_data   <= w_dec;
      r_s2_status <= w_status;
      r_s2_user   <= r_s1_user;
      r_s2_last   <= r_s1_last;
    end
  end

  // Error counters; clear wins over a same-cycle increment
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else if (CNT_CLR) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else begin
      r_cnt_corr   <= w_corr_next;
      r_cnt_uncorr <= w_uncorr_next;
    end
  end

  assign OUT_VALID   = r_s2_valid;
  assign OUT_DECODED = r_s2_data;
  assign OUT_STATUS  = r_s2_status;
  assign OUT_USER    = r_s2_user;
  assign OUT_LAST    = r_s2_last;
  assign CNT_CORR    = r_cnt_corr;
  assign CNT_UNCORR  = r_cnt_uncorr;

endmodule

// File: tb/tb_lpc_product_decoder.sv
// Directed bench for lpc_product_decoder (8x8): vector table on a counting instance,
// plus drop/saturation/clear on a CW=2, DROP_UNCORR=1 instance, back-pressure and reset.
module tb_lpc_product_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [79:0] a_tdata = '0, b_tdata = '0;
  logic a_tvalid = 1'b0, a_tuser = 1'b0, a_tlast = 1'b0, a_oready = 1'b1, a_clr = 1'b0;
  logic b_tvalid = 1'b0, b_tuser = 1'b0, b_tlast = 1'b0, b_oready = 1'b1, b_clr = 1'b0;
  logic a_tready, a_ovalid, a_olast, a_ouser, b_tready, b_ovalid, b_olast, b_ouser;
  logic [63:0] a_dec, b_dec;
  logic [1:0] a_stat, b_stat;
  logic [15:0] a_ccorr, a_cunc;
  logic [1:0] b_ccorr, b_cunc;

  lpc_product_decoder #(.ROWS(8), .COLS(8), .CW(16), .DROP_UNCORR(0)) dut_a (
    .ACLK(clk), .ARESET_N(rst_n), .TDATA(a_tdata), .TVALID(a_tvalid), .TREADY(a_tready),
    .TUSER(a_tuser), .TLAST(a_tlast), .OUT_DECODED(a_dec), .OUT_VALID(a_ovalid),
    .OUT_READY(a_oready), .OUT_LAST(a_olast), .OUT_USER(a_ouser), .OUT_STATUS(a_stat),
    .CNT_CORR(a_ccorr), .CNT_UNCORR(a_cunc), .CNT_CLR(a_clr));

  lpc_product_decoder #(.ROWS(8), .COLS(8), .CW(2), .DROP_UNCORR(1)) dut_b (
    .ACLK(clk), .ARESET_N(rst_n), .TDATA(b_tdata), .TVALID(b_tvalid), .TREADY(b_tready),
    .TUSER(b_tuser), .TLAST(b_tlast), .OUT_DECODED(b_dec), .OUT_VALID(b_ovalid),
    .OUT_READY(b_oready), .OUT_LAST(b_olast), .OUT_USER(b_ouser), .OUT_STATUS(b_stat),
    .CNT_CORR(b_ccorr), .CNT_UNCORR(b_cunc), .CNT_CLR(b_clr));

  typedef struct {
    logic [79:0] code;
    logic        user;
    logic        last;
    logic [63:0] exp_data;
    logic [1:0]  exp_stat;
  } vec_t;

  int total = 0;
  int bad = 0;
  int exp_corr = 0;
  int exp_unc = 0;
  localparam logic [63:0] BASE = 64'h0123456789ABCDEF;

  // Even row/column parity: TDATA = {col parity, row parity, data}
  function automatic logic [79:0] enc(input logic [63:0] d);
    logic [7:0] rp;
    logic [7:0] cp;
    rp = 8'h00;
    cp = 8'h00;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rp[r] = rp[r] ^ d[r*8+c];
        cp[c] = cp[c] ^ d[r*8+c];
      end
    return {cp, rp, d};
  endfunction

  function automatic logic [79:0] bit80(input int idx);
    logic [79:0] one;
    one = 80'd1;
    return one << idx;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One isolated beat through dut_a with latency, content and counter checks
  task automatic send_a(input vec_t v, input string tag);
    @(negedge clk);
    check({tag, "_tready"}, 80'(a_tready), 80'd1);
    a_tdata = v.code; a_tuser = v.user; a_tlast = v.last; a_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_tvalid = 1'b0;
    check({tag, "_valid_k1"}, 80'(a_ovalid), 80'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_k2"}, 80'(a_ovalid), 80'd1);
    check({tag, "_data"}, 80'(a_dec), 80'(v.exp_data));
    check({tag, "_status"}, 80'(a_stat), 80'(v.exp_stat));
    check({tag, "_user"}, 80'(a_ouser), 80'(v.user));
    check({tag, "_last"}, 80'(a_olast), 80'(v.last));
    if (v.exp_stat == 2'b01 || v.exp_stat == 2'b10) exp_corr++;
    if (v.exp_stat == 2'b11) exp_unc++;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_after"}, 80'(a_ovalid), 80'd0);
    check({tag, "_cnt_corr"}, 80'(a_ccorr), 80'(exp_corr));
    check({tag, "_cnt_uncorr"}, 80'(a_cunc), 80'(exp_unc));
  endtask

  task automatic send_b(input logic [79:0] code, input logic user, input logic last);
    @(negedge clk);
    b_tdata = code; b_tuser = user; b_tlast = last; b_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_tvalid = 1'b0;
  endtask

  // Leaves the caller at a negedge with b_ovalid=1, or reports not found
  task automatic wait_bvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b_ovalid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  vec_t vecs[10];
  logic [79:0] c0;
  logic [79:0] bp_code[6];
  logic [63:0] bp_data[6];
  logic [1:0]  bp_stat[6];
  logic        bp_user[6];
  logic        bp_last[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int seen;
    int in_idx, out_idx, occ;
    logic seen_low, prev_stall, exp_tr;
    logic [63:0] prev_dec;

    c0 = enc(BASE);
    vecs[0] = '{c0, 1'b0, 1'b0, BASE, 2'b00};
    vecs[1] = '{c0 ^ bit80(19), 1'b1, 1'b0, BASE, 2'b01};
    vecs[2] = '{c0 ^ bit80(66), 1'b0, 1'b1, BASE, 2'b10};
    vecs[3] = '{c0 ^ bit80(77), 1'b1, 1'b1, BASE, 2'b10};
    vecs[4] = '{c0 ^ bit80(0) ^ bit80(9), 1'b0, 1'b0, BASE ^ 64'h0000_0000_0000_0201, 2'b11};
    vecs[5] = '{c0 ^ bit80(63), 1'b0, 1'b0, BASE, 2'b01};
    vecs[6] = '{c0 ^ bit80(0), 1'b1, 1'b0, BASE, 2'b01};
    vecs[7] = '{c0 ^ bit80(0) ^ bit80(1), 1'b0, 1'b1, BASE ^ 64'h0000_0000_0000_0003, 2'b11};
    vecs[8] = '{c0 ^ bit80(5) ^ bit80(64), 1'b1, 1'b0, BASE ^ 64'h0000_0000_0000_0020, 2'b10};
    vecs[9] = '{enc(64'hFFFF0000A5A55A5A), 1'b1, 1'b1, 64'hFFFF0000A5A55A5A, 2'b00};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_tready", 80'(a_tready), 80'd1);
    check("rst_a_valid", 80'(a_ovalid), 80'd0);
    check("rst_a_data", 80'(a_dec), 80'd0);
    check("rst_a_status", 80'(a_stat), 80'd0);
    check("rst_a_cnt_corr", 80'(a_ccorr), 80'd0);
    check("rst_a_cnt_uncorr", 80'(a_cunc), 80'd0);
    check("rst_b_tready", 80'(b_tready), 80'd1);
    check("rst_b_valid", 80'(b_ovalid), 80'd0);

    for (int i = 0; i < 10; i++) send_a(vecs[i], $sformatf("vec%0d", i));

    // Dropped uncorrectable beat: never presented, still counted
    send_b(c0 ^ bit80(0) ^ bit80(9), 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (b_ovalid) seen++;
      @(negedge clk);
    end
    check("drop_absent", 80'(seen), 80'd0);
    check("drop_cnt_uncorr", 80'(b_cunc), 80'd1);

    // Same beat with TLAST=1 must be delivered
    send_b(c0 ^ bit80(0) ^ bit80(9), 1'b1, 1'b1);
    wait_bvalid(ok);
    check("droplast_present", 80'(ok), 80'd1);
    check("droplast_status", 80'(b_stat), 80'd3);
    check("droplast_last", 80'(b_olast), 80'd1);
    check("droplast_user", 80'(b_ouser), 80'd1);
    @(negedge clk);
    check("droplast_cnt_uncorr", 80'(b_cunc), 80'd2);

    // CW=2 saturation after five corrected beats
    for (int i = 0; i < 5; i++) begin
      send_b(c0 ^ bit80(19), 1'b0, 1'b0);
      repeat (3) @(negedge clk);
    end
    check("sat_cnt_corr", 80'(b_ccorr), 80'd3);

    // Clear coincides with the sixth beat's handshake: clear wins
    send_b(c0 ^ bit80(19), 1'b0, 1'b0);
    wait_bvalid(ok);
    check("clr_beat_present", 80'(ok), 80'd1);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    check("clr_cnt_corr", 80'(b_ccorr), 80'd0);
    check("clr_cnt_uncorr", 80'(b_cunc), 80'd0);
    send_b(c0 ^ bit80(40), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("post_clr_cnt_corr", 80'(b_ccorr), 80'd1);

    // Back-pressure stream: OUT_READY low in cycles 3..7
    for (int i = 0; i < 6; i++) begin
      bp_data[i] = BASE ^ (64'(i) << 40);
      bp_code[i] = enc(bp_data[i]);
      bp_stat[i] = 2'b00;
      if (i % 2 == 1) begin
        bp_code[i] = bp_code[i] ^ bit80(i * 11);
        bp_stat[i] = 2'b01;
      end
      bp_user[i] = (i % 3 == 0);
      bp_last[i] = (i == 2) || (i == 5);
    end
    in_idx = 0; out_idx = 0; occ = 0; seen_low = 1'b0; prev_stall = 1'b0; prev_dec = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      a_oready = !(cyc >= 3 && cyc <= 7);
      if (in_idx < 6) begin
        a_tdata = bp_code[in_idx]; a_tuser = bp_user[in_idx]; a_tlast = bp_last[in_idx];
        a_tvalid = 1'b1;
      end else begin
        a_tvalid = 1'b0;
      end
      #1;
      exp_tr = (occ < 2) || a_oready;
      check($sformatf("bp_tready_c%0d", cyc), 80'(a_tready), 80'(exp_tr));
      if (!a_tready) seen_low = 1'b1;
      if (prev_stall) begin
        check($sformatf("bp_hold_valid_c%0d", cyc), 80'(a_ovalid), 80'd1);
        check($sformatf("bp_hold_data_c%0d", cyc), 80'(a_dec), 80'(prev_dec));
      end
      if (a_ovalid && a_oready) begin
        if (out_idx < 6) begin
          check($sformatf("bp_data_%0d", out_idx), 80'(a_dec), 80'(bp_data[out_idx]));
          check($sformatf("bp_status_%0d", out_idx), 80'(a_stat), 80'(bp_stat[out_idx]));
          check($sformatf("bp_user_%0d", out_idx), 80'(a_ouser), 80'(bp_user[out_idx]));
          check($sformatf("bp_last_%0d", out_idx), 80'(a_olast), 80'(bp_last[out_idx]));
        end else begin
          check("bp_extra_beat", 80'(out_idx), 80'd5);
        end
        out_idx++;
        occ--;
      end
      if (a_tvalid && a_tready) begin
        in_idx++;
        occ++;
      end
      prev_stall = a_ovalid && !a_oready;
      prev_dec = a_dec;
    end
    check("bp_accepted", 80'(in_idx), 80'd6);
    check("bp_emitted", 80'(out_idx), 80'd6);
    check("bp_tready_fell", 80'(seen_low), 80'd1);

    // Reset with two beats in flight
    @(negedge clk);
    a_oready = 1'b1;
    a_tdata = vecs[1].code; a_tuser = 1'b0; a_tlast = 1'b0; a_tvalid = 1'b1;
    @(negedge clk);
    a_tdata = vecs[2].code;
    @(negedge clk);
    a_tvalid = 1'b0;
    check("pre_rst_valid", 80'(a_ovalid), 80'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 80'(a_ovalid), 80'd0);
    check("midrst_cnt_corr", 80'(a_ccorr), 80'd0);
    check("midrst_cnt_uncorr", 80'(a_cunc), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_corr = 0;
    exp_unc = 0;
    send_a(vecs[0], "after_rst_clean");
    send_a(vecs[6], "after_rst_corr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
